present_sched: RTL and testbench

- Scheduler and arbiter that shares one present cipher core between two block requesters.
- Owns the core's key-schedule restart and datapath clear.
- Round-robin arbitration over two valid/ready request channels.
- Each granted block runs as a single encrypt or decrypt operation; the result is returned on a shared response channel tagged with the requester id.

---
 rtl/present_sched_if.sv | 38 +++
 rtl/present_sched.sv | 270 +++++++++++++++++++++++++++
 tb/tb_present_sched.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/present_sched_if.sv
// present_sched_if
//   Request/response bus between the two block requesters and present_sched.
//   Two valid/ready request channels (req0, req1) carry a 64-bit block and a
//   direction bit each. One shared valid/ready response channel returns the
//   result block, the requester id and a watchdog-abort flag.
//   slave  : the scheduler side (drives ready and the response).
//   master : the requester side (drives valid, block, dec and rsp_ready).
interface present_sched_if;
   logic        req0_valid_i;
   logic        req0_ready_o;
   logic [63:0] req0_block_i;
   logic        req0_dec_i;
   logic        req1_valid_i;
   logic        req1_ready_o;
   logic [63:0] req1_block_i;
   logic        req1_dec_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic        rsp_id_o;
   logic [63:0] rsp_block_o;
   logic        rsp_err_o;

   modport slave (
      input  req0_valid_i, req0_block_i, req0_dec_i,
      input  req1_valid_i, req1_block_i, req1_dec_i,
      input  rsp_ready_i,
      output req0_ready_o, req1_ready_o,
      output rsp_valid_o, rsp_id_o, rsp_block_o, rsp_err_o
   );

   modport master (
      output req0_valid_i, req0_block_i, req0_dec_i,
      output req1_valid_i, req1_block_i, req1_dec_i,
      output rsp_ready_i,
      input  req0_ready_o, req1_ready_o,
      input  rsp_valid_o, rsp_id_o, rsp_block_o, rsp_err_o
   );
endinterface

// File: rtl/present_sched.sv
// present_sched
//   Shares one PRESENT cipher core between two block requesters. Owns the
//   core's key-schedule restart (core_krst_o) and datapath clear
//   (core_dclr_o), arbitrates round-robin between the two request channels,
//   runs each granted block as one encrypt or decrypt, and returns the result
//   on the shared response channel tagged with the requester id. A watchdog
//   aborts an operation that runs TIMEOUT cycles and forces a re-key.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   key_i/key_load_i  80-bit key and its load pulse
//   key_ready_o       round keys valid, requests may be granted
//   bus               request/response channels (present_sched_if.slave)
//   core_*            key, block, direction, restart/clear to the core;
//                     result and end-of-key/enc/dec status from the core
//   busy_o            scheduler not idle
module present_sched #(
   parameter int TIMEOUT     = 64,
   parameter int KRST_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [79:0]           key_i,
   input  logic                  key_load_i,
   output logic                  key_ready_o,
   present_sched_if.slave        bus,
   output logic [79:0]           core_key_o,
   output logic                  core_krst_o,
   output logic                  core_dclr_o,
   output logic                  core_enc_dec_o,
   output logic [63:0]           core_block_o,
   input  logic [63:0]           core_result_i,
   input  logic                  core_end_key_i,
   input  logic                  core_end_enc_i,
   input  logic                  core_end_dec_i,
   output logic                  busy_o
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam int KC_W = $clog2(KRST_CYCLES + 1);

   localparam logic [2:0] ST_KRST  = 3'd0;
   localparam logic [2:0] ST_KWAIT = 3'd1;
   localparam logic [2:0] ST_IDLE  = 3'd2;
   localparam logic [2:0] ST_ARB   = 3'd3;
   localparam logic [2:0] ST_CLR   = 3'd4;
   localparam logic [2:0] ST_RUN   = 3'd5;
   localparam logic [2:0] ST_RSP   = 3'd6;

   logic [2:0]      state_q,     state_d;
   logic [KC_W-1:0] kcnt_q,      kcnt_d;
   logic [WD_W-1:0] wdog_q,      wdog_d;
   logic [79:0]     key_q,       key_d;
   logic            pend_q,      pend_d;
   logic [79:0]     pend_key_q,  pend_key_d;
   logic            key_ready_q, key_ready_d;
   logic            rr_q,        rr_d;
   logic            gid_q,       gid_d;
   logic [63:0]     blk_q,       blk_d;
   logic            dec_q,       dec_d;
   logic [63:0]     result_q,    result_d;
   logic            err_q,       err_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            rdy0_q,      rdy0_d;
   logic            rdy1_q,      rdy1_d;
   logic            dclr_q,      dclr_d;
   logic            krst_q,      krst_d;
   logic            busy_q,      busy_d;

   logic            grant_id;
   logic            sel_valid;
   logic            end_hit;

   // rr_q remembers the last grant; with both valid the other one wins
   assign grant_id  = (bus.req0_valid_i && bus.req1_valid_i) ? ~rr_q : bus.req1_valid_i;
   assign sel_valid = gid_q ? bus.req1_valid_i : bus.req0_valid_i;
   assign end_hit   = dec_q ? core_end_dec_i : core_end_enc_i;

   // Next-state and next-output logic of the scheduler
   always_comb begin
      state_d     = state_q;
      kcnt_d      = kcnt_q;
      wdog_d      = wdog_q;
      key_d       = key_q;
      pend_d      = pend_q;
      pend_key_d  = pend_key_q;
      key_ready_d = key_ready_q;
      rr_d        = rr_q;
      gid_d       = gid_q;
      blk_d       = blk_q;
      dec_d       = dec_q;
      result_d    = result_q;
      err_d       = err_q;
      rsp_valid_d = rsp_valid_q;
      rdy0_d      = rdy0_q;
      rdy1_d      = rdy1_q;
      dclr_d      = dclr_q;
      krst_d      = krst_q;

      // A load outside IDLE must not disturb the key the core is using;
      // park it and apply it on the next IDLE entry.
      if (key_load_i && (state_q != ST_IDLE)) begin
         pend_d     = 1'b1;
         pend_key_d = key_i;
      end else begin
         pend_d     = pend_q;
      end

      case (state_q)
         ST_KRST: begin
            krst_d = 1'b1;
            if (kcnt_q == KC_W'(KRST_CYCLES - 1)) begin
               state_d = ST_KWAIT;
               krst_d  = 1'b0;
               kcnt_d  = '0;
            end else begin
               kcnt_d  = kcnt_q + KC_W'(1);
            end
         end
         ST_KWAIT: begin
            if (core_end_key_i) begin
               state_d     = ST_IDLE;
               key_ready_d = 1'b1;
            end else begin
               state_d     = ST_KWAIT;
            end
         end
         ST_IDLE: begin
            // Key changes take priority over any grant
            if (key_load_i || pend_q) begin
               key_d       = key_load_i ? key_i : pend_key_q;
               pend_d      = 1'b0;
               key_ready_d = 1'b0;
               krst_d      = 1'b1;
               kcnt_d      = '0;
               state_d     = ST_KRST;
            end else if (key_ready_q && (bus.req0_valid_i || bus.req1_valid_i)) begin
               gid_d   = grant_id;
               rr_d    = grant_id;
               rdy0_d  = ~grant_id;
               rdy1_d  = grant_id;
               state_d = ST_ARB;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARB: begin
            rdy0_d = 1'b0;
            rdy1_d = 1'b0;
            // A requester that withdrew during ARB simply gets no operation
            if (sel_valid) begin
               blk_d   = gid_q ? bus.req1_block_i : bus.req0_block_i;
               dec_d   = gid_q ? bus.req1_dec_i   : bus.req0_dec_i;
               state_d = ST_CLR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLR: begin
            dclr_d  = 1'b0;
            wdog_d  = '0;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (end_hit) begin
               result_d    = core_result_i;
               err_d       = 1'b0;
               rsp_valid_d = 1'b1;
               dclr_d      = 1'b1;
               state_d     = ST_RSP;
            end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
               result_d    = 64'h0;
               err_d       = 1'b1;
               rsp_valid_d = 1'b1;
               dclr_d      = 1'b1;
               state_d     = ST_RSP;
            end else begin
               wdog_d      = wdog_q + WD_W'(1);
            end
         end
         ST_RSP: begin
            if (bus.rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               // After a watchdog abort the core state is unknown: re-key
               if (err_q) begin
                  key_ready_d = 1'b0;
                  krst_d      = 1'b1;
                  kcnt_d      = '0;
                  state_d     = ST_KRST;
               end else begin
                  state_d     = ST_IDLE;
               end
            end else begin
               state_d = ST_RSP;
            end
         end
         default: begin
            key_ready_d = 1'b0;
            rsp_valid_d = 1'b0;
            rdy0_d      = 1'b0;
            rdy1_d      = 1'b0;
            dclr_d      = 1'b1;
            krst_d      = 1'b1;
            kcnt_d      = '0;
            state_d     = ST_KRST;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_KRST;
         kcnt_q      <= '0;
         wdog_q      <= '0;
         key_q       <= 80'h0;
         pend_q      <= 1'b0;
         pend_key_q  <= 80'h0;
         key_ready_q <= 1'b0;
         rr_q        <= 1'b1;
         gid_q       <= 1'b0;
         blk_q       <= 64'h0;
         dec_q       <= 1'b0;
         result_q    <= 64'h0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdy0_q      <= 1'b0;
         rdy1_q      <= 1'b0;
         dclr_q      <= 1'b1;
         krst_q      <= 1'b1;
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         kcnt_q      <= kcnt_d;
         wdog_q      <= wdog_d;
         key_q       <= key_d;
         pend_q      <= pend_d;
         pend_key_q  <= pend_key_d;
         key_ready_q <= key_ready_d;
         rr_q        <= rr_d;
         gid_q       <= gid_d;
         blk_q       <= blk_d;
         dec_q       <= dec_d;
         result_q    <= result_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         rdy0_q      <= rdy0_d;
         rdy1_q      <= rdy1_d;
         dclr_q      <= dclr_d;
         krst_q      <= krst_d;
         busy_q      <= busy_d;
      end
   end

   assign key_ready_o      = key_ready_q;
   assign bus.req0_ready_o = rdy0_q;
   assign bus.req1_ready_o = rdy1_q;
   assign bus.rsp_valid_o  = rsp_valid_q;
   assign bus.rsp_id_o     = gid_q;
   assign bus.rsp_block_o  = result_q;
   assign bus.rsp_err_o    = err_q;
   assign core_key_o       = key_q;
   assign core_krst_o      = krst_q;
   assign core_dclr_o      = dclr_q;
   assign core_enc_dec_o   = dec_q;
   assign core_block_o     = blk_q;
   assign busy_o           = busy_q;

endmodule

// File: tb/tb_present_sched.sv
module tb_present_sched;
   localparam int TIMEOUT     = 64;
   localparam int KRST_CYCLES = 2;
   localparam int CORE_LAT    = 33;
   localparam int KEY_LAT     = 3;

   logic        clk;
   logic        rst;
   logic [79:0] key_i;
   logic        key_load_i;
   logic        key_ready_o;
   logic [79:0] core_key_o;
   logic        core_krst_o, core_dclr_o, core_enc_dec_o;
   logic [63:0] core_block_o;
   logic [63:0] core_result_i;
   logic        core_end_key_i, core_end_enc_i, core_end_dec_i;
   logic        busy_o;

   present_sched_if bus ();

   present_sched #(.TIMEOUT(TIMEOUT), .KRST_CYCLES(KRST_CYCLES)) dut (
      .clk(clk), .rst(rst), .key_i(key_i), .key_load_i(key_load_i),
      .key_ready_o(key_ready_o), .bus(bus),
      .core_key_o(core_key_o), .core_krst_o(core_krst_o), .core_dclr_o(core_dclr_o),
      .core_enc_dec_o(core_enc_dec_o), .core_block_o(core_block_o),
      .core_result_i(core_result_i), .core_end_key_i(core_end_key_i),
      .core_end_enc_i(core_end_enc_i), .core_end_dec_i(core_end_dec_i),
      .busy_o(busy_o)
   );

   int checks   = 0;
   int failures = 0;
   int viol     = 0;
   int last_gnt = 1;
   bit core_dead = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- PRESENT-80 reference ----------------
   function automatic logic [3:0] sb(input logic [3:0] x);
      case (x)
         4'h0: sb = 4'hC; 4'h1: sb = 4'h5; 4'h2: sb = 4'h6; 4'h3: sb = 4'hB;
         4'h4: sb = 4'h9; 4'h5: sb = 4'h0; 4'h6: sb = 4'hA; 4'h7: sb = 4'hD;
         4'h8: sb = 4'h3; 4'h9: sb = 4'hE; 4'hA: sb = 4'hF; 4'hB: sb = 4'h8;
         4'hC: sb = 4'h4; 4'hD: sb = 4'h7; 4'hE: sb = 4'h1; 4'hF: sb = 4'h2;
         default: sb = 4'h0;
      endcase
   endfunction

   function automatic logic [3:0] isb(input logic [3:0] y);
      isb = 4'h0;
      for (int j = 0; j < 16; j++) if (sb(4'(j)) == y) isb = 4'(j);
   endfunction

   function automatic logic [63:0] s_layer(input logic [63:0] s, input bit inv);
      for (int n = 0; n < 16; n++) s[4*n +: 4] = inv ? isb(s[4*n +: 4]) : sb(s[4*n +: 4]);
      return s;
   endfunction

   function automatic logic [63:0] p_layer(input logic [63:0] s, input bit inv);
      logic [63:0] o;
      o = 64'h0;
      for (int i = 0; i < 64; i++) begin
         int p;
         p = (i == 63) ? 63 : (i * 16) % 63;
         if (!inv) o[p] = s[i];
         else      o[i] = s[p];
      end
      return o;
   endfunction

   function automatic logic [63:0] present(input logic [63:0] blk, input logic [79:0] key, input bit dec);
      logic [63:0] rk [1:32];
      logic [79:0] k;
      logic [63:0] s;
      k = key;
      for (int r = 1; r <= 32; r++) begin
         rk[r] = k[79:16];
         k = {k[18:0], k[79:19]};
         k[79:76] = sb(k[79:76]);
         k[19:15] = k[19:15] ^ 5'(r);
      end
      s = blk;
      if (!dec) begin
         for (int r = 1; r <= 31; r++) s = p_layer(s_layer(s ^ rk[r], 1'b0), 1'b0);
         s = s ^ rk[32];
      end else begin
         s = s ^ rk[32];
         for (int r = 31; r >= 1; r--) s = s_layer(p_layer(s, 1'b1), 1'b1) ^ rk[r];
      end
      return s;
   endfunction

   // ---------------- behavioural core ----------------
   int key_cnt, dp_cnt;
   // Core model: key schedule after krst, fixed-latency datapath after dclr
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_cnt <= 0; dp_cnt <= 0;
         core_end_key_i <= 1'b0; core_end_enc_i <= 1'b0; core_end_dec_i <= 1'b0;
         core_result_i <= 64'h0;
      end else begin
         if (core_krst_o) begin
            key_cnt <= 0; core_end_key_i <= 1'b0;
         end else if (!core_end_key_i) begin
            key_cnt <= key_cnt + 1;
            if (key_cnt == KEY_LAT - 1) core_end_key_i <= 1'b1;
         end
         if (core_dclr_o) begin
            dp_cnt <= 0; core_end_enc_i <= 1'b0; core_end_dec_i <= 1'b0;
            core_result_i <= 64'h0;
         end else if (!core_dead && !core_end_enc_i && !core_end_dec_i) begin
            dp_cnt <= dp_cnt + 1;
            if (dp_cnt == CORE_LAT - 1) begin
               core_result_i  <= present(core_block_o, core_key_o, core_enc_dec_o);
               core_end_enc_i <= !core_enc_dec_o;
               core_end_dec_i <= core_enc_dec_o;
            end
         end
      end
   end

   // Protocol monitor: direction stable while running, ready rules
   logic prev_ed = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         if ((!core_dclr_o && core_enc_dec_o !== prev_ed) ||
             ((bus.req0_ready_o || bus.req1_ready_o) && !key_ready_o) ||
             (bus.req0_ready_o && bus.req1_ready_o))
            viol <= viol + 1;
      end
      prev_ed <= core_enc_dec_o;
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   task automatic set_req(input int id, input logic v, input logic [63:0] b, input logic d);
      if (id == 0) begin
         bus.req0_valid_i = v; bus.req0_block_i = b; bus.req0_dec_i = d;
      end else begin
         bus.req1_valid_i = v; bus.req1_block_i = b; bus.req1_dec_i = d;
      end
   endtask

   task automatic wait_grant(output int g, output bit ok);
      ok = 1'b0; g = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.req0_ready_o) begin g = 0; ok = 1'b1; break; end
         if (bus.req1_ready_o) begin g = 1; ok = 1'b1; break; end
      end
   endtask

   task automatic wait_rsp(output bit ok, output int cyc);
      ok = 1'b0; cyc = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         cyc = i + 1;
         if (bus.rsp_valid_o) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_key_ready(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (key_ready_o) begin ok = 1'b1; break; end
      end
      chk(tag, ok, 1'b1);
   endtask

   task automatic accept();
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
   endtask

   task automatic load_key(input logic [79:0] k, input string tag);
      key_i = k; key_load_i = 1'b1;
      @(negedge clk);
      key_load_i = 1'b0;
      chk({tag, "_kready_low"}, key_ready_o, 1'b0);
      wait_key_ready({tag, "_kready_high"});
      chk({tag, "_core_key"}, core_key_o, k);
   endtask

   task automatic run_op(input int id, input logic [63:0] blk, input logic dec,
                         input logic [63:0] exp, input logic exp_err, input string tag);
      int g, c;
      bit ok;
      set_req(id, 1'b1, blk, dec);
      wait_grant(g, ok);
      chk({tag, "_grant"}, g, id);
      @(negedge clk);
      set_req(id, 1'b0, 64'h0, 1'b0);
      wait_rsp(ok, c);
      chk({tag, "_rsp_valid"}, ok, 1'b1);
      chk({tag, "_rsp_id"}, bus.rsp_id_o, id);
      chk({tag, "_rsp_block"}, bus.rsp_block_o, exp);
      chk({tag, "_rsp_err"}, bus.rsp_err_o, exp_err);
      accept();
      last_gnt = id;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1);
   end

   // ---------------- directed + randomized sequence ----------------
   initial begin
      int g, c, n, id;
      bit ok, seen;
      logic [63:0] b [2];
      logic        d [2];
      logic [63:0] blk, exp;
      logic [79:0] cur_key;
      logic        dec;

      rst = 1'b0; key_i = 80'h0; key_load_i = 1'b0;
      bus.req0_valid_i = 1'b0; bus.req0_block_i = 64'h0; bus.req0_dec_i = 1'b0;
      bus.req1_valid_i = 1'b0; bus.req1_block_i = 64'h0; bus.req1_dec_i = 1'b0;
      bus.rsp_ready_i = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_key_ready", key_ready_o, 1'b0);
      chk("rst_ready0", bus.req0_ready_o, 1'b0);
      chk("rst_ready1", bus.req1_ready_o, 1'b0);
      chk("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
      chk("rst_krst", core_krst_o, 1'b1);
      chk("rst_dclr", core_dclr_o, 1'b1);
      chk("rst_core_key", core_key_o, 80'h0);
      chk("rst_rsp_block", bus.rsp_block_o, 64'h0);

      // Release reset; krst must stay high for KRST_CYCLES core edges
      rst = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (!core_krst_o) break;
         n++;
         @(negedge clk);
      end
      chk("krst_len", n, KRST_CYCLES);
      wait_key_ready("boot_kready");
      chk("idle_busy", busy_o, 1'b0);
      cur_key = 80'h0;

      // Known answers: key 0 and all-ones
      run_op(0, 64'h0, 1'b0, 64'h5579C1387B228445, 1'b0, "kat_k0");
      load_key({80{1'b1}}, "load_ones");
      cur_key = {80{1'b1}};
      run_op(1, 64'h0, 1'b0, 64'hE72C46C0F5945049, 1'b0, "kat_k1_enc");
      run_op(1, 64'hE72C46C0F5945049, 1'b1, 64'h0, 1'b0, "kat_k1_dec");

      // Both requesters valid: grants alternate
      b[0] = rand64(); b[1] = rand64(); d[0] = 1'b0; d[1] = 1'b1;
      set_req(0, 1'b1, b[0], d[0]);
      set_req(1, 1'b1, b[1], d[1]);
      for (int k = 0; k < 4; k++) begin
         wait_grant(g, ok);
         chk($sformatf("alt%0d_grant", k), g, 1 - last_gnt);
         if (g < 0) g = 1 - last_gnt;
         blk = b[g]; dec = d[g];
         @(negedge clk);
         if (k == 3) begin
            set_req(0, 1'b0, 64'h0, 1'b0);
            set_req(1, 1'b0, 64'h0, 1'b0);
         end else begin
            b[g] = rand64();
            set_req(g, 1'b1, b[g], d[g]);
         end
         last_gnt = g;
         wait_rsp(ok, c);
         chk($sformatf("alt%0d_rsp_id", k), bus.rsp_id_o, g);
         chk($sformatf("alt%0d_rsp_block", k), bus.rsp_block_o, present(blk, cur_key, dec));
         accept();
      end

      // Backpressure: response held, no new grant while waiting
      blk = rand64();
      exp = present(blk, cur_key, 1'b0);
      set_req(0, 1'b1, blk, 1'b0);
      wait_grant(g, ok);
      @(negedge clk);
      set_req(0, 1'b0, 64'h0, 1'b0);
      wait_rsp(ok, c);
      b[1] = rand64();
      set_req(1, 1'b1, b[1], 1'b0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp_rsp_valid", bus.rsp_valid_o, 1'b1);
         chk("bp_rsp_block", bus.rsp_block_o, exp);
         chk("bp_rsp_id", bus.rsp_id_o, 1'b0);
         chk("bp_no_grant", bus.req1_ready_o, 1'b0);
         chk("bp_busy", busy_o, 1'b1);
      end
      accept();
      last_gnt = 0;
      wait_grant(g, ok);
      chk("bp_next_grant", g, 1);
      @(negedge clk);
      set_req(1, 1'b0, 64'h0, 1'b0);
      wait_rsp(ok, c);
      chk("bp_next_block", bus.rsp_block_o, present(b[1], cur_key, 1'b0));
      accept();
      last_gnt = 1;

      // Key load during RUN is deferred to the next IDLE
      load_key(80'h0, "load_zero");
      set_req(0, 1'b1, 64'h0, 1'b0);
      wait_grant(g, ok);
      @(negedge clk);
      set_req(0, 1'b0, 64'h0, 1'b0);
      repeat (5) @(negedge clk);
      key_i = {80{1'b1}}; key_load_i = 1'b1;
      @(negedge clk);
      key_load_i = 1'b0;
      key_i = {$urandom, $urandom, $urandom};
      chk("runload_kready", key_ready_o, 1'b1);
      chk("runload_core_key", core_key_o, 80'h0);
      wait_rsp(ok, c);
      chk("runload_block", bus.rsp_block_o, 64'h5579C1387B228445);
      accept();
      last_gnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!key_ready_o) seen = 1'b1;
         @(negedge clk);
      end
      chk("runload_rekey_seen", seen, 1'b1);
      wait_key_ready("runload_kready_back");
      chk("runload_new_key", core_key_o, {80{1'b1}});
      cur_key = {80{1'b1}};
      run_op(0, 64'h0, 1'b0, 64'hE72C46C0F5945049, 1'b0, "runload_next");

      // Randomized operations under a random key
      cur_key = {$urandom, $urandom, $urandom};
      load_key(cur_key, "load_rand");
      for (int k = 0; k < 6; k++) begin
         id  = int'($urandom_range(1, 0));
         blk = rand64();
         dec = 1'($urandom_range(1, 0));
         run_op(id, blk, dec, present(blk, cur_key, dec), 1'b0, $sformatf("rand%0d", k));
      end

      // Watchdog: core never finishes
      core_dead = 1'b1;
      set_req(1, 1'b1, 64'h1234, 1'b0);
      wait_grant(g, ok);
      @(negedge clk);
      set_req(1, 1'b0, 64'h0, 1'b0);
      wait_rsp(ok, c);
      chk("wd_latency", 1 + c, TIMEOUT + 2);
      chk("wd_err", bus.rsp_err_o, 1'b1);
      chk("wd_block", bus.rsp_block_o, 64'h0);
      chk("wd_id", bus.rsp_id_o, 1'b1);
      accept();
      last_gnt = 1;
      chk("wd_krst", core_krst_o, 1'b1);
      chk("wd_kready", key_ready_o, 1'b0);
      core_dead = 1'b0;
      wait_key_ready("wd_rekey");
      chk("wd_same_key", core_key_o, cur_key);

      // Asynchronous reset mid-RUN
      set_req(0, 1'b1, rand64(), 1'b0);
      wait_grant(g, ok);
      @(negedge clk);
      set_req(0, 1'b0, 64'h0, 1'b0);
      repeat (8) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_rsp_valid", bus.rsp_valid_o, 1'b0);
      chk("arst_kready", key_ready_o, 1'b0);
      chk("arst_krst", core_krst_o, 1'b1);
      chk("arst_dclr", core_dclr_o, 1'b1);
      chk("arst_core_key", core_key_o, 80'h0);
      @(negedge clk);
      rst = 1'b1;
      last_gnt = 1;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.rsp_valid_o) seen = 1'b1;
         if (key_ready_o) break;
      end
      chk("arst_no_rsp", seen, 1'b0);
      chk("arst_kready_back", key_ready_o, 1'b1);

      // Pointer back at reset value: req0 wins a tie
      set_req(0, 1'b1, 64'h0, 1'b0);
      set_req(1, 1'b1, 64'h0, 1'b0);
      wait_grant(g, ok);
      chk("arst_tie_grant", g, 0);
      @(negedge clk);
      set_req(0, 1'b0, 64'h0, 1'b0);
      set_req(1, 1'b0, 64'h0, 1'b0);
      wait_rsp(ok, c);
      chk("arst_tie_block", bus.rsp_block_o, 64'h5579C1387B228445);
      accept();

      chk("protocol_violations", viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
